// File: rtl/rob_multiport_pkg.sv
// Shared types and default sizes for the multi-port reorder buffer.
// ROB_PACKET is the per-instruction payload carried from dispatch to retire.
package rob_multiport_pkg;

  localparam int ROB_DEPTH    = 32;
  localparam int ROB_IDX_BITS = $clog2(ROB_DEPTH);
  localparam int ROB_CNT_BITS = $clog2(ROB_DEPTH + 1);
  localparam int DISPATCH_W   = 2;
  localparam int RETIRE_W     = 2;
  localparam int ROB_CDB_W    = 2;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [5:0]  dest_reg;
    logic        halt;
  } ROB_PACKET;

`ifdef DEBUG
  typedef struct packed {
    logic [ROB_IDX_BITS-1:0] head;
    logic [ROB_IDX_BITS-1:0] tail;
    logic [ROB_CNT_BITS-1:0] count;
    logic [ROB_DEPTH-1:0]    done;
  } ROB_MP_DEBUG;
`endif

endpackage

// File: rtl/rob_multiport_retire_select.sv
// Counts the run of completed entries starting at head, capped by the
// commit-side limit and by the number of live entries.
module rob_retire_select
  import rob_multiport_pkg::*;
#(
  parameter  int RET_W    = RETIRE_W,
  parameter  int CNT_BITS = ROB_CNT_BITS,
  localparam int RC_BITS  = $clog2(RET_W + 1)
) (
  input  logic [RET_W-1:0]   done_window,
  input  logic [RC_BITS-1:0] retire_limit,
  input  logic [CNT_BITS-1:0] count,
  output logic [RC_BITS-1:0] run_length
);

  logic run_open;

  always_comb begin
    run_length = '0;
    run_open   = 1'b1;
    for (int i = 0; i < RET_W; i++) begin
      if (run_open && done_window[i] && (i < int'(retire_limit)) && (i < int'(count))) begin
        run_length = RC_BITS'(i + 1);
      end else begin
        run_open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Parametrised multi-port reorder buffer: in-order dispatch and retire,
// out-of-order completion, and squash-restore from the branch's own index.
module rob_multiport
  import rob_multiport_pkg::*;
#(
  parameter  int DEPTH    = ROB_DEPTH,
  parameter  int DISP_W   = DISPATCH_W,
  parameter  int RET_W    = RETIRE_W,
  parameter  int CDB_W    = ROB_CDB_W,
  localparam int IDX_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = $clog2(DEPTH + 1),
  localparam int DC_BITS  = $clog2(DISP_W + 1),
  localparam int RC_BITS  = $clog2(RET_W + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  ROB_PACKET           disp_packets [DISP_W],
  input  logic [DC_BITS-1:0]  disp_count,
  output logic [DC_BITS-1:0]  disp_spots,
  output logic [IDX_BITS-1:0] tail,
  input  logic [CDB_W-1:0]    cdb_valid,
  input  logic [IDX_BITS-1:0] cdb_idx [CDB_W],
  input  logic [RC_BITS-1:0]  retire_limit,
  output ROB_PACKET           retire_packets [RET_W],
  output logic [RC_BITS-1:0]  retire_count,
  output logic [IDX_BITS-1:0] head,
  input  logic                squash_valid,
  input  logic [IDX_BITS-1:0] squash_idx,
  output logic [CNT_BITS-1:0] num_entries
`ifdef DEBUG
  ,
  output ROB_MP_DEBUG         debug
`endif
);

  localparam logic [CNT_BITS:0] DEPTH_X = (CNT_BITS+1)'(DEPTH);

  // Single conditional subtract is enough: a < DEPTH and b <= DEPTH.
  function automatic logic [IDX_BITS-1:0] idx_add(input logic [IDX_BITS-1:0] a,
                                                   input logic [CNT_BITS-1:0] b);
    logic [CNT_BITS:0] sum;
    sum = (CNT_BITS+1)'(a) + (CNT_BITS+1)'(b);
    if (sum >= DEPTH_X) sum = sum - DEPTH_X;
    return sum[IDX_BITS-1:0];
  endfunction

  ROB_PACKET             entries_reg [DEPTH];
  logic [DEPTH-1:0]      done_reg, done_next;
  logic [IDX_BITS-1:0]   head_reg, head_next;
  logic [IDX_BITS-1:0]   tail_reg, tail_next;
  logic [CNT_BITS-1:0]   count_reg, count_next;

  logic [IDX_BITS-1:0]   ret_idx [RET_W];
  logic [RET_W-1:0]      done_window;
  logic [IDX_BITS-1:0]   disp_idx [DISP_W];
  logic [DISP_W-1:0]     disp_we;
  logic [CNT_BITS-1:0]   free_cnt;
  logic [CNT_BITS-1:0]   squash_dist;

  for (genvar gi = 0; gi < RET_W; gi++) begin : g_ret
    assign ret_idx[gi]        = idx_add(head_reg, CNT_BITS'(gi));
    assign done_window[gi]    = done_reg[ret_idx[gi]];
    assign retire_packets[gi] = (gi < int'(retire_count)) ? entries_reg[ret_idx[gi]] : '0;
  end

  for (genvar gi = 0; gi < DISP_W; gi++) begin : g_disp
    assign disp_idx[gi] = idx_add(tail_reg, CNT_BITS'(gi));
    assign disp_we[gi]  = !squash_valid && (gi < int'(disp_count));
  end

  rob_retire_select #(
    .RET_W    (RET_W),
    .CNT_BITS (CNT_BITS)
  ) u_retire_select (
    .done_window  (done_window),
    .retire_limit (retire_limit),
    .count        (count_reg),
    .run_length   (retire_count)
  );

  assign free_cnt   = CNT_BITS'(DEPTH) - count_reg;
  assign disp_spots = (free_cnt >= CNT_BITS'(DISP_W)) ? DC_BITS'(DISP_W) : DC_BITS'(free_cnt);

  // Age of the branch relative to head; count stays exact even when full.
  assign squash_dist = (squash_idx >= head_reg)
                     ? CNT_BITS'(squash_idx - head_reg)
                     : CNT_BITS'(squash_idx) + CNT_BITS'(DEPTH) - CNT_BITS'(head_reg);

  always_comb begin
    head_next = idx_add(head_reg, CNT_BITS'(retire_count));
    if (squash_valid) begin
      tail_next  = idx_add(squash_idx, CNT_BITS'(1));
      count_next = squash_dist + CNT_BITS'(1) - CNT_BITS'(retire_count);
    end else begin
      tail_next  = idx_add(tail_reg, CNT_BITS'(disp_count));
      count_next = count_reg + CNT_BITS'(disp_count) - CNT_BITS'(retire_count);
    end

    // Allocation is applied after completion so it wins on the same index.
    done_next = done_reg;
    for (int p = 0; p < CDB_W; p++) begin
      if (cdb_valid[p]) done_next[cdb_idx[p]] = 1'b1;
    end
    for (int d = 0; d < DISP_W; d++) begin
      if (disp_we[d]) done_next[disp_idx[d]] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      done_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      for (int d = 0; d < DISP_W; d++) begin
        if (disp_we[d]) entries_reg[disp_idx[d]] <= disp_packets[d];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (squash_valid || (disp_count <= disp_spots))
        else $error("rob_multiport: disp_count exceeds disp_spots");
      assert (!squash_valid || (squash_dist < count_reg))
        else $error("rob_multiport: squash_idx is not a live entry");
    end
  end

  assign head        = head_reg;
  assign tail        = tail_reg;
  assign num_entries = count_reg;

`ifdef DEBUG
  assign debug.head  = ROB_IDX_BITS'(head_reg);
  assign debug.tail  = ROB_IDX_BITS'(tail_reg);
  assign debug.count = ROB_CNT_BITS'(count_reg);
  assign debug.done  = ROB_DEPTH'(done_reg);
`endif

endmodule

// File: doc/rob_multiport.md
# rob_multiport

Parametrised multi-port reorder buffer, the successor to the current fixed-`N` ROB. It sits between Dispatch, the CDB/writeback stage, Retire and the branch stack. New features over the current ROB:
- depth, dispatch width, retire width and completion-port count are all parameters;
- per-entry completion tracking, with retire selection done in-block;
- a squash restore computed from the branch's own ROB index, so full and empty are never confused.

## Interface
Parameters:
- `DEPTH`, 32: entry count; any value ≥ 2, not restricted to powers of two.
- `DISP_W`, 2: maximum instructions dispatched per cycle.
- `RET_W`, 2: maximum instructions retired per cycle.
- `CDB_W`, 2: number of completion ports.
- Derived: `IDX_BITS` = clog2(`DEPTH`); `CNT_BITS` = clog2(`DEPTH`+1).

Ports:
- `clock`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `disp_packets`  in  `DISP_W`×ROB_PACKET  oldest first, at index 0.
- `disp_count`  in  clog2(`DISP_W`+1)  number of valid `disp_packets`, a count (not a mask).
- `disp_spots`  out  clog2(`DISP_W`+1)  min(free entries, `DISP_W`).
- `tail`  out  `IDX_BITS`  index the next dispatched entry `disp_packets[0]` will occupy.
- `cdb_valid`  in  `CDB_W`  completion strobe per port.
- `cdb_idx`  in  `CDB_W`×`IDX_BITS`  ROB index being completed.
- `retire_limit`  in  clog2(`RET_W`+1)  maximum retires the commit side accepts this cycle.
- `retire_packets`  out  `RET_W`×ROB_PACKET  entries head..head+`RET_W`-1; zero beyond `retire_count`.
- `retire_count`  out  clog2(`RET_W`+1)  entries retiring this cycle.
- `head`  out  `IDX_BITS`  oldest entry index.
- `squash_valid`  in  1  branch mispredict restore.
- `squash_idx`  in  `IDX_BITS`  ROB index of the mispredicted branch; the branch itself is kept.
- `num_entries`  out  `CNT_BITS`  live entry count.

## Operation
State:
- `entries[DEPTH]` (packet), `done[DEPTH]` (1 bit each), `head`, `tail`, `count`.
- `count` alone determines empty (0) and full (`DEPTH`). Pointer equality is never used for this.

Retire (combinational from registered state):
- `retire_count` = length of the run of consecutive `done` entries starting at `head`.
- The run is capped at min(`RET_W`, `retire_limit`, `count`).
- Retirement is consumed at the clock edge: `head` advances by `retire_count`, modulo `DEPTH`.

Dispatch:
- Entries `tail`..`tail+disp_count-1` (mod `DEPTH`) are written, with their `done` bits cleared.
- `disp_count` > `disp_spots` is illegal; an assertion fires and behaviour is undefined.

Completion:
- Each port with `cdb_valid` set writes `done[cdb_idx]`=1.
- Two ports naming the same index is legal.
- Allocation and completion of the same index in the same cycle: allocation wins (`done`=0).

Pointer and count update:
- Modular arithmetic: (a+b) ≥ `DEPTH` ? a+b-`DEPTH` : a+b. Never `%` on non-power-of-two depths.
- Normal cycle: `count` ← `count` + `disp_count` − `retire_count`.

Squash (`squash_valid`=1):
- `disp_count` is ignored (nothing written).
- Retirement still occurs.
- `tail` ← `squash_idx`+1 (mod `DEPTH`).
- `count` ← ((`squash_idx` − `head`) mod `DEPTH`) + 1 − `retire_count`, using the pre-edge `head`.
- Completion writes still apply; stale `done` bits on freed slots are harmless because allocation clears them.
- `squash_idx` must name a live entry; an assertion checks this.

Reset:
- `head`=`tail`=`count`=0; all `done`=0; entries zeroed.
- Outputs: `disp_spots`=min(`DEPTH`,`DISP_W`); `retire_count`=0; `retire_packets`=0; `head`=`tail`=0; `num_entries`=0.

## Timing
- `disp_spots`, `retire_*`, `head`, `tail` and `num_entries` depend only on registered state. No combinational path from any input except `retire_limit` → `retire_count`/`retire_packets`.
- Completion → retire eligibility: 1 cycle. A CDB write at edge k allows retire in cycle k+1; there is no bypass.
- Dispatch → completion: a dispatch written at edge k can be completed by a CDB write in cycle k+1 at the earliest.
- Space freed by retire at edge k appears in `disp_spots` in cycle k+1.
- Squash at edge k: the restored `tail`/`count` are visible in cycle k+1, and dispatch resumes there.
- Reset asserted mid-operation overrides squash, dispatch and completion in that same cycle.

## Structure
- ROB_PACKET stays in `sys_defs.svh`.
- Add to `sys_defs.svh`: `ROB_DEPTH`, `ROB_IDX_BITS`, `ROB_CNT_BITS`, `RETIRE_W`, `CDB_W` as defaults for the parameters.
- Sub-module `rob_retire_select`: combinational leading-ones run counter over the `RET_W` `done` bits (rotated from `head`), capped by `retire_limit` and `count`. Outputs the run length.
- Debug struct `ROB_MP_DEBUG` under `ifdef DEBUG`, exposing `head`, `tail`, `count` and `done`.

## Test plan
1. Reset, `DEPTH`=5, `DISP_W`=2 → `disp_spots`=2, `num_entries`=0. Dispatch 2 per cycle for 3 cycles (last dispatch 1 entry) → `tail` 2, 4, 0; `count`=5; `disp_spots`=0.
2. Complete index 1 only (head=0) → `retire_count`=0. Complete index 0 → next cycle `retire_count`=2 and `head`→2 after the edge.
3. All entries done, `retire_limit`=1 → exactly 1 retire per cycle. Set `retire_limit`=0 → `retire_count`=0.
4. Full ROB (`count`=5, head=3), squash `squash_idx`=2 (youngest) → `count` stays 5, `tail`=3. Squash `squash_idx`=3 (oldest) → `count`=1, `tail`=4.
5. Squash with simultaneous 1-entry retire of the branch itself (head=idx=3) → `count`=0, `tail`=4=`head`.
6. Same-cycle CDB to a slot being re-allocated → `done`=0. Reset mid-dispatch → all outputs return to their reset values next cycle.
